// File: rtl/cmlb_ctrl_pkg.sv
// cmlb_ctrl_pkg
// Shared definitions for the code MLB fill / maintenance sequencer:
//   - fill_state_e : sequencer state encoding
//   - FLUSH_CNT_W  : width of the invalidate sweep counter (512 sets)
//   - TIMEOUT_W / TIMEOUT_MAX : walk-response watchdog sizing, used only
//     when CMLB_FILL_TIMEOUT_EN is defined
//   - CMLB_DATA_W  : CMLB entry payload width, taken from `cmlbData_width

`ifndef cmlbData_width
`define cmlbData_width 64
`endif

package cmlb_ctrl_pkg;

    localparam int CMLB_DATA_W = `cmlbData_width;

    localparam int FLUSH_CNT_W = 9;

    localparam int TIMEOUT_W   = 10;
    localparam int TIMEOUT_MAX = 1023;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FILL  = 3'd3,
        ST_FLUSH = 3'd4
    } fill_state_e;

endpackage

// File: rtl/cmlb_fill_timer.sv
// cmlb_fill_timer
// Watchdog for an outstanding page-walk request. The counter is held at
// zero while clear is high and advances while enable is high; expire is
// raised once TIMEOUT_MAX cycles have elapsed with enable continuously set.
// The module exists only when CMLB_FILL_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force the count back to zero
//   enable    : count this cycle
//   expire    : count has reached TIMEOUT_MAX while enabled

`ifdef CMLB_FILL_TIMEOUT_EN
module cmlb_fill_timer
    import cmlb_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;
    logic                 at_max;

    assign at_max = (cnt_q == TIMEOUT_W'(TIMEOUT_MAX));
    assign expire = enable && at_max;

    // Saturate at the limit so a stuck enable cannot wrap and hide the expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/cmlb_fill_ctrl.sv
// cmlb_fill_ctrl
// Miss and maintenance sequencer for the code MLB. Accepts one fetch miss
// at a time, issues a page-walk request, writes the returned entry into the
// CMLB for one cycle, and runs a full 512-set invalidate sweep on request.
// While it owns the CMLB it drives the array address/write mux and stalls
// fetch.
// Optional build macro: CMLB_FILL_TIMEOUT_EN adds a walk-response watchdog
// that turns a 1023-cycle silent wait into a fault.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   miss_valid/addr/tr/thread    : fetch miss report; miss_ready accepts it
//   walk_req_valid/addr/tr/thread, walk_req_ready : walk request handshake
//   walk_rsp_valid/data/fault    : walker response
//   cmlb_addr, cmlb_tr           : CMLB index/transl_jump while busy
//   cmlb_write_wen/data          : CMLB entry write
//   cmlb_inval                   : invalidate the indexed set
//   fstall                       : fetch stall
//   fault_valid, fault_addr      : walk fault report (pulse + address)
//   flush_req, flush_done        : invalidate sweep request / completion pulse

module cmlb_fill_ctrl
    import cmlb_ctrl_pkg::*;
#(
    parameter int IP_WIDTH = 65,
    parameter int DATA_W   = CMLB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                miss_valid,
    input  logic [IP_WIDTH-1:0] miss_addr,
    input  logic                miss_tr,
    input  logic                miss_thread,
    output logic                miss_ready,

    output logic                walk_req_valid,
    output logic [IP_WIDTH-1:0] walk_req_addr,
    output logic                walk_req_tr,
    output logic                walk_req_thread,
    input  logic                walk_req_ready,

    input  logic                walk_rsp_valid,
    input  logic [DATA_W-1:0]   walk_rsp_data,
    input  logic                walk_rsp_fault,

    output logic [IP_WIDTH-1:0] cmlb_addr,
    output logic                cmlb_tr,
    output logic                cmlb_write_wen,
    output logic [DATA_W-1:0]   cmlb_write_data,
    output logic                cmlb_inval,
    output logic                fstall,

    output logic                fault_valid,
    output logic [IP_WIDTH-1:0] fault_addr,

    input  logic                flush_req,
    output logic                flush_done
);

    fill_state_e              state_q, state_d;
    logic [IP_WIDTH-1:0]      addr_q, addr_d;
    logic                     tr_q, tr_d;
    logic                     thread_q, thread_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     flush_pending_q, flush_pending_d;
    logic [FLUSH_CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                     fault_valid_q, fault_valid_d;
    logic [IP_WIDTH-1:0]      fault_addr_q, fault_addr_d;
    logic                     flush_done_q, flush_done_d;

    logic [IP_WIDTH-1:0]      flush_addr;
    logic                     timeout_expire;

`ifdef CMLB_FILL_TIMEOUT_EN
    cmlb_fill_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_WAIT),
        .enable (state_q == ST_WAIT),
        .expire (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
`endif

    // The sweep counter's low byte is replicated into both index fields of
    // the CMLB address; the top bit selects the transl_jump half.
    always_comb begin
        flush_addr        = '0;
        flush_addr[21:14] = flush_cnt_q[7:0];
        flush_addr[11:4]  = flush_cnt_q[7:0];
    end

    // Walk request fields are only presented while the request is live.
    assign walk_req_addr   = walk_req_valid ? addr_q : '0;
    assign walk_req_tr     = walk_req_valid ? tr_q : 1'b0;
    assign walk_req_thread = walk_req_valid ? thread_q : 1'b0;

    assign cmlb_write_data = data_q;
    assign fault_valid     = fault_valid_q;
    assign fault_addr      = fault_addr_q;
    assign flush_done      = flush_done_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        tr_d            = tr_q;
        thread_d        = thread_q;
        data_d          = data_q;
        flush_pending_d = flush_pending_q;
        flush_cnt_d     = '0;
        fault_valid_d   = 1'b0;
        fault_addr_d    = fault_addr_q;
        flush_done_d    = 1'b0;

        miss_ready      = 1'b0;
        walk_req_valid  = 1'b0;
        cmlb_addr       = '0;
        cmlb_tr         = 1'b0;
        cmlb_write_wen  = 1'b0;
        cmlb_inval      = 1'b0;
        fstall          = 1'b0;

        // A flush arriving while a miss is in flight is remembered and run
        // once the miss has finished; during a sweep it is simply absorbed.
        if (flush_req && (state_q inside {ST_REQ, ST_WAIT, ST_FILL})) begin
            flush_pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (flush_req || flush_pending_q) begin
                    state_d         = ST_FLUSH;
                    flush_pending_d = 1'b0;
                end else begin
                    miss_ready = 1'b1;
                    if (miss_valid) begin
                        addr_d   = miss_addr;
                        tr_d     = miss_tr;
                        thread_d = miss_thread;
                        state_d  = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                walk_req_valid = 1'b1;
                fstall         = 1'b1;
                cmlb_addr      = addr_q;
                cmlb_tr        = tr_q;
                if (walk_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            // A real response beats a watchdog expiry in the same cycle.
            ST_WAIT: begin
                fstall    = 1'b1;
                cmlb_addr = addr_q;
                cmlb_tr   = tr_q;
                if (walk_rsp_valid) begin
                    if (walk_rsp_fault) begin
                        fault_valid_d = 1'b1;
                        fault_addr_d  = addr_q;
                        state_d       = ST_IDLE;
                    end else begin
                        data_d  = walk_rsp_data;
                        state_d = ST_FILL;
                    end
                end else if (timeout_expire) begin
                    fault_valid_d = 1'b1;
                    fault_addr_d  = addr_q;
                    state_d       = ST_IDLE;
                end
            end

            ST_FILL: begin
                fstall         = 1'b1;
                cmlb_write_wen = 1'b1;
                cmlb_addr      = addr_q;
                cmlb_tr        = tr_q;
                state_d        = ST_IDLE;
            end

            ST_FLUSH: begin
                fstall      = 1'b1;
                cmlb_inval  = 1'b1;
                cmlb_addr   = flush_addr;
                cmlb_tr     = flush_cnt_q[FLUSH_CNT_W-1];
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == {FLUSH_CNT_W{1'b1}}) begin
                    flush_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            tr_q            <= 1'b0;
            thread_q        <= 1'b0;
            data_q          <= '0;
            flush_pending_q <= 1'b0;
            flush_cnt_q     <= '0;
            fault_valid_q   <= 1'b0;
            fault_addr_q    <= '0;
            flush_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            tr_q            <= tr_d;
            thread_q        <= thread_d;
            data_q          <= data_d;
            flush_pending_q <= flush_pending_d;
            flush_cnt_q     <= flush_cnt_d;
            fault_valid_q   <= fault_valid_d;
            fault_addr_q    <= fault_addr_d;
            flush_done_q    <= flush_done_d;
        end
    end

endmodule

// File: tb/tb_cmlb_fill_ctrl.sv
// tb_cmlb_fill_ctrl
// Directed bench for cmlb_fill_ctrl: fill with delayed response, stalled
// walk request, faulting walk, flush deferred behind a miss, absorbed
// flush_req during a sweep, reset mid-walk, and the optional timeout.

module tb_cmlb_fill_ctrl;
    import cmlb_ctrl_pkg::*;

    localparam int IP_WIDTH = 65;
    localparam int DATA_W   = CMLB_DATA_W;

    logic                clk;
    logic                rst;
    logic                miss_valid;
    logic [IP_WIDTH-1:0] miss_addr;
    logic                miss_tr;
    logic                miss_thread;
    logic                miss_ready;
    logic                walk_req_valid;
    logic [IP_WIDTH-1:0] walk_req_addr;
    logic                walk_req_tr;
    logic                walk_req_thread;
    logic                walk_req_ready;
    logic                walk_rsp_valid;
    logic [DATA_W-1:0]   walk_rsp_data;
    logic                walk_rsp_fault;
    logic [IP_WIDTH-1:0] cmlb_addr;
    logic                cmlb_tr;
    logic                cmlb_write_wen;
    logic [DATA_W-1:0]   cmlb_write_data;
    logic                cmlb_inval;
    logic                fstall;
    logic                fault_valid;
    logic [IP_WIDTH-1:0] fault_addr;
    logic                flush_req;
    logic                flush_done;

    int errors;
    int checks;
    int reqAccepts;
    int wenCount;

    cmlb_fill_ctrl #(
        .IP_WIDTH (IP_WIDTH),
        .DATA_W   (DATA_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_valid      (miss_valid),
        .miss_addr       (miss_addr),
        .miss_tr         (miss_tr),
        .miss_thread     (miss_thread),
        .miss_ready      (miss_ready),
        .walk_req_valid  (walk_req_valid),
        .walk_req_addr   (walk_req_addr),
        .walk_req_tr     (walk_req_tr),
        .walk_req_thread (walk_req_thread),
        .walk_req_ready  (walk_req_ready),
        .walk_rsp_valid  (walk_rsp_valid),
        .walk_rsp_data   (walk_rsp_data),
        .walk_rsp_fault  (walk_rsp_fault),
        .cmlb_addr       (cmlb_addr),
        .cmlb_tr         (cmlb_tr),
        .cmlb_write_wen  (cmlb_write_wen),
        .cmlb_write_data (cmlb_write_data),
        .cmlb_inval      (cmlb_inval),
        .fstall          (fstall),
        .fault_valid     (fault_valid),
        .fault_addr      (fault_addr),
        .flush_req       (flush_req),
        .flush_done      (flush_done)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted walk requests and CMLB writes seen at the active edge.
    always @(posedge clk) begin
        if (walk_req_valid && walk_req_ready) reqAccepts <= reqAccepts + 1;
        if (cmlb_write_wen) wenCount <= wenCount + 1;
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle and settle 1 unit past the edge before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a miss on the fetch side.
    task automatic applyStimulus(input logic valid, input logic [IP_WIDTH-1:0] addr,
                                 input logic tr, input logic thread);
        miss_valid  = valid;
        miss_addr   = addr;
        miss_tr     = tr;
        miss_thread = thread;
    endtask

    initial begin
        logic [IP_WIDTH-1:0] addr1, addr2, addr3, addr4, expAddr;
        logic [8:0]          idx;

        errors = 0; checks = 0; reqAccepts = 0; wenCount = 0;
        addr1 = 65'h1_2345_6000;
        addr2 = 65'h0_0000_1230;
        addr3 = 65'h0_ffff_fff0;
        addr4 = 65'h1_0000_0040;

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        walk_req_ready = 1'b0;
        walk_rsp_valid = 1'b0;
        walk_rsp_data  = '0;
        walk_rsp_fault = 1'b0;
        flush_req      = 1'b0;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_miss_ready", miss_ready, 1);
        checkOutput("rst_fstall", fstall, 0);
        checkOutput("rst_walk_req_valid", walk_req_valid, 0);
        checkOutput("rst_wen", cmlb_write_wen, 0);
        checkOutput("rst_inval", cmlb_inval, 0);
        checkOutput("rst_fault_valid", fault_valid, 0);
        checkOutput("rst_flush_done", flush_done, 0);
        checkOutput("rst_cmlb_addr", cmlb_addr, 0);
        rst = 1'b0;

        // Test 1: plain fill, walker ready at once, response a few cycles later.
        applyStimulus(1'b1, addr1, 1'b0, 1'b1);
        walk_req_ready = 1'b1;
        checkOutput("t1_miss_ready", miss_ready, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t1_req_valid", walk_req_valid, 1);
        checkOutput("t1_req_addr", walk_req_addr, addr1);
        checkOutput("t1_req_thread", walk_req_thread, 1);
        checkOutput("t1_req_tr", walk_req_tr, 0);
        checkOutput("t1_fstall_req", fstall, 1);
        checkOutput("t1_miss_ready_busy", miss_ready, 0);
        tick();
        checkOutput("t1_wait_req_valid", walk_req_valid, 0);
        checkOutput("t1_fstall_wait", fstall, 1);
        repeat (3) tick();
        checkOutput("t1_no_early_wen", cmlb_write_wen, 0);
        walk_rsp_valid = 1'b1;
        walk_rsp_data  = DATA_W'(64'hABCD);
        tick();
        walk_rsp_valid = 1'b0;
        walk_rsp_data  = '0;
        checkOutput("t1_wen", cmlb_write_wen, 1);
        checkOutput("t1_fill_addr", cmlb_addr, addr1);
        checkOutput("t1_fill_tr", cmlb_tr, 0);
        checkOutput("t1_fill_data", cmlb_write_data, 64'hABCD);
        checkOutput("t1_fstall_fill", fstall, 1);
        tick();
        checkOutput("t1_wen_off", cmlb_write_wen, 0);
        checkOutput("t1_fstall_idle", fstall, 0);
        checkOutput("t1_idle_ready", miss_ready, 1);

        // Test 2: walker stalls the request four cycles; stray response in REQ.
        applyStimulus(1'b1, addr2, 1'b1, 1'b0);
        walk_req_ready = 1'b0;
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t2_req_valid_hold", walk_req_valid, 1);
            checkOutput("t2_req_addr_hold", walk_req_addr, addr2);
            checkOutput("t2_req_tr_hold", walk_req_tr, 1);
            walk_rsp_valid = (k == 1);
            walk_rsp_data  = DATA_W'(64'h9999);
            tick();
        end
        walk_rsp_valid = 1'b0;
        checkOutput("t2_stray_rsp_no_wen", cmlb_write_wen, 0);
        checkOutput("t2_req_valid_5th", walk_req_valid, 1);
        walk_req_ready = 1'b1;
        tick();
        checkOutput("t2_wait_req_valid", walk_req_valid, 0);
        checkOutput("t2_one_accept", reqAccepts, 2);
        walk_rsp_valid = 1'b1;
        walk_rsp_fault = 1'b1;
        tick();
        walk_rsp_valid = 1'b0;
        walk_rsp_fault = 1'b0;
        checkOutput("t2_fault_valid", fault_valid, 1);
        checkOutput("t2_fault_addr", fault_addr, addr2);
        checkOutput("t2_fault_no_wen", cmlb_write_wen, 0);
        checkOutput("t2_fault_idle", miss_ready, 1);
        tick();
        checkOutput("t2_fault_pulse", fault_valid, 0);

        // Test 3: flush during WAIT is deferred until the fill completes.
        applyStimulus(1'b1, addr3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        flush_req = 1'b1;
        checkOutput("t3_wait_fstall", fstall, 1);
        tick();
        flush_req = 1'b0;
        checkOutput("t3_no_inval_wait", cmlb_inval, 0);
        walk_rsp_valid = 1'b1;
        walk_rsp_data  = DATA_W'(64'h55AA);
        tick();
        walk_rsp_valid = 1'b0;
        checkOutput("t3_fill_wen", cmlb_write_wen, 1);
        checkOutput("t3_fill_data", cmlb_write_data, 64'h55AA);
        checkOutput("t3_fill_no_inval", cmlb_inval, 0);
        tick();
        // Pending flush and a new miss in the same IDLE cycle: flush wins.
        applyStimulus(1'b1, addr4, 1'b1, 1'b1);
        checkOutput("t3_flush_wins_ready", miss_ready, 0);
        checkOutput("t3_idle_no_inval", cmlb_inval, 0);
        tick();
        for (int i = 0; i < 512; i++) begin
            idx = 9'(i);
            expAddr = '0;
            expAddr[21:14] = idx[7:0];
            expAddr[11:4]  = idx[7:0];
            checkOutput("t3_inval", cmlb_inval, 1);
            checkOutput("t3_inval_tr", cmlb_tr, idx[8]);
            checkOutput("t3_inval_addr", cmlb_addr, expAddr);
            if (i == 0 || i == 511) begin
                checkOutput("t3_sweep_fstall", fstall, 1);
                checkOutput("t3_sweep_no_done", flush_done, 0);
            end
            flush_req = (i == 100);
            tick();
        end
        flush_req = 1'b0;
        checkOutput("t3_flush_done", flush_done, 1);
        checkOutput("t3_after_sweep_inval", cmlb_inval, 0);
        checkOutput("t3_absorbed_ready", miss_ready, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t3_done_pulse", flush_done, 0);
        checkOutput("t3_held_miss_req", walk_req_valid, 1);
        checkOutput("t3_held_miss_addr", walk_req_addr, addr4);
        checkOutput("t3_held_miss_thread", walk_req_thread, 1);
        tick();
        checkOutput("t3_wait_fstall2", fstall, 1);

        // Test 4: reset in WAIT, then a late response is ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t4_reset_ready", miss_ready, 1);
        checkOutput("t4_reset_fstall", fstall, 0);
        checkOutput("t4_reset_req_valid", walk_req_valid, 0);
        tick();
        walk_rsp_valid = 1'b1;
        walk_rsp_data  = DATA_W'(64'h1111);
        tick();
        walk_rsp_valid = 1'b0;
        checkOutput("t4_late_rsp_no_wen", cmlb_write_wen, 0);
        checkOutput("t4_late_rsp_fstall", fstall, 0);
        checkOutput("t4_late_rsp_ready", miss_ready, 1);
        checkOutput("t4_total_writes", wenCount, 2);

`ifdef CMLB_FILL_TIMEOUT_EN
        // Test 5: no response; watchdog raises a fault 1024 cycles into WAIT.
        applyStimulus(1'b1, addr1, 1'b0, 1'b0);
        walk_req_ready = 1'b1;
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        repeat (1023) tick();
        checkOutput("t5_no_early_fault", fault_valid, 0);
        tick();
        checkOutput("t5_timeout_fault", fault_valid, 1);
        checkOutput("t5_timeout_addr", fault_addr, addr1);
        checkOutput("t5_timeout_no_wen", cmlb_write_wen, 0);
        checkOutput("t5_timeout_idle", miss_ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmlb_fill_ctrl.md
# cmlb_fill_ctrl

Miss and maintenance sequencer for the code MLB. Accepts fetch-side translation misses, issues one page-walk request at a time to the walker, and writes the returned entry into the CMLB for exactly one cycle. It also runs a full-array invalidate sweep on request. It owns the CMLB write and address mux and stalls fetch while it uses the array.

## Interface
- IP_WIDTH, 65, virtual address width (matches CMLB).
- DATA_W, `cmlbData_width`, CMLB entry payload width.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- miss_valid  in  1  fetch reports a CMLB miss.
- miss_addr  in  IP_WIDTH  missing address.
- miss_tr  in  1  miss is on a translated jump (transl_jump).
- miss_thread  in  1  requesting thread.
- miss_ready  out  1  miss accepted this cycle.
- walk_req_valid  out  1  walk request.
- walk_req_addr  out  IP_WIDTH; walk_req_tr  out  1; walk_req_thread  out  1.
- walk_req_ready  in  1  walker accepts.
- walk_rsp_valid  in  1; walk_rsp_data  in  DATA_W; walk_rsp_fault  in  1.
- cmlb_addr  out  IP_WIDTH  address driven to CMLB while busy.
- cmlb_tr  out  1  transl_jump driven to CMLB.
- cmlb_write_wen  out  1; cmlb_write_data  out  DATA_W.
- cmlb_inval  out  1  invalidate the indexed set.
- fstall  out  1  fetch stall.
- fault_valid  out  1 (pulse); fault_addr  out  IP_WIDTH.
- flush_req  in  1  request a full invalidate (level or pulse).
- flush_done  out  1  pulse when the sweep completes.

## Operation
- States: IDLE, REQ, WAIT, FILL, FLUSH.
- IDLE: a pending flush has priority; go to FLUSH. Otherwise miss_ready=1. On miss_valid, latch addr/tr/thread and go to REQ.
- REQ: walk_req_valid=1 with latched fields, held stable until walk_req_ready. Then go to WAIT.
- WAIT: on walk_rsp_valid with fault=0, latch data and go to FILL. With fault=1, pulse fault_valid, set fault_addr to the latched address, and go to IDLE with no write.
- FILL: cmlb_write_wen=1 for one cycle. cmlb_addr and cmlb_tr come from the latched miss, cmlb_write_data from the latched response. Then go to IDLE.
- FLUSH: a 9-bit counter c runs 0..511. cmlb_inval=1 and cmlb_tr=c[8]. cmlb_addr is zero except bits [21:14] and [11:4], which both equal c[7:0]. After c=511, pulse flush_done and go to IDLE.
- flush_req arriving outside IDLE/FLUSH sets flush_pending. The sweep runs after the current miss completes. flush_req during FLUSH is absorbed and does not restart the sweep.
- walk_rsp_valid in any state other than WAIT is ignored.
- fstall=1 in REQ, WAIT, FILL and FLUSH.

## Timing
- Reset: state IDLE, counters 0, flush_pending 0. All outputs 0 except miss_ready=1 (IDLE, no flush pending).
- Reset mid-walk or mid-flush aborts it. A late walker response is ignored.
- Miss accepted in cycle N: walk_req_valid asserts in N+1.
- Response in cycle M: write in M+1, IDLE in M+2, next miss can be accepted in M+2.
- Fault in cycle M: fault_valid in M+1.
- Flush starting in cycle F: invalidates in cycles F+1..F+512, flush_done in F+513.
- Miss and flush in the same IDLE cycle: flush wins, miss_ready=0, and the miss waits.

## Configuration
- CMLB_FILL_TIMEOUT_EN:
  - Defined: a 10-bit counter runs in WAIT. If 1023 cycles pass without a response, treat it as a fault (fault_valid pulse, IDLE, no write).
  - Undefined: WAIT is unbounded and the counter logic is absent.

## Structure
- Shared package cmlb_ctrl_pkg holds:
  - state enum;
  - FLUSH_CNT_W=9;
  - TIMEOUT_W=10, TIMEOUT_MAX=1023.
- Optional sub-module cmlb_fill_timer, instantiated only under CMLB_FILL_TIMEOUT_EN. It takes clear/enable and outputs expire.

## Test plan
- Miss addr=0x1_2345_6000, tr=0; walker ready at once, response data=0xABCD after 5 cycles -> one cmlb_write_wen cycle with that addr and data; fstall high from N+1 through the fill; IDLE afterwards.
- walk_req_ready held low for 4 cycles -> walk_req_valid and walk_req_addr stay stable all 4 cycles; only one request is accepted.
- Response with walk_rsp_fault=1 -> fault_valid for one cycle, fault_addr = miss address, no cmlb_write_wen.
- flush_req during WAIT -> fill completes first, then 512 cmlb_inval cycles with index 0..255 for tr=0 then tr=1, then flush_done for one cycle.
- rst asserted in WAIT, then walk_rsp_valid 2 cycles later -> no write; miss_ready=1 after reset.
- With CMLB_FILL_TIMEOUT_EN and no response -> fault_valid 1024 cycles after entering WAIT.
